// File: rtl/video_shift_ctrl_if.sv
// Signal bundle between mode decode / CRTC sync sources and the video shift sequencer.
// Mode write, sync and display-enable inputs flow in; shifter controls and status flow out.
interface video_shift_ctrl_if;
    logic       SYNC_PH;
    logic       HSYNC;
    logic       MODE_WR;
    logic [1:0] MODE_IN;
    logic       DISPEN;
    logic       LOAD;
    logic       SHIFT;
    logic       KEEP;
    logic [1:0] MODE_ACT;
    logic       BORDER;
    logic [2:0] PHASE;

    modport master (
        output SYNC_PH,
        output HSYNC,
        output MODE_WR,
        output MODE_IN,
        output DISPEN,
        input  LOAD,
        input  SHIFT,
        input  KEEP,
        input  MODE_ACT,
        input  BORDER,
        input  PHASE
    );

    modport slave (
        input  SYNC_PH,
        input  HSYNC,
        input  MODE_WR,
        input  MODE_IN,
        input  DISPEN,
        output LOAD,
        output SHIFT,
        output KEEP,
        output MODE_ACT,
        output BORDER,
        output PHASE
    );
endinterface

// File: rtl/video_shift_ctrl.sv
// Gate Array video shift sequencer: byte-phase counter, HSYNC-armed mode register, border latch.
// Controls decode combinationally from registered state (zero latency); no backpressure, free-running.
module video_shift_ctrl #(
    parameter logic [1:0] RESET_MODE = 2'd1
) (
    input  logic                 CLK_n,
    input  logic                 RESET_n,
    video_shift_ctrl_if.slave    vs
);

    localparam logic [2:0] PH_LAST = 3'd7;
    localparam logic [2:0] PH_MID  = 3'd3;

    logic [2:0] ph_q,        ph_d;
    logic       hsync_q,     hsync_d;
    logic       armed_q,     armed_d;
    logic [1:0] mode_pend_q, mode_pend_d;
    logic [1:0] mode_act_q,  mode_act_d;
    logic       border_q,    border_d;

    logic       byte_end;
    logic       hs_rise;
    logic       apply;

    logic       load_c;
    logic       shift_c;
    logic       keep_c;

    assign byte_end = (ph_q == PH_LAST);
    assign hs_rise  = vs.HSYNC & ~hsync_q;
    assign apply    = byte_end & armed_q;

    always_comb begin
        ph_d        = ph_q + 3'd1;
        hsync_d     = vs.HSYNC;
        armed_d     = armed_q;
        mode_pend_d = mode_pend_q;
        mode_act_d  = mode_act_q;
        border_d    = border_q;

        if (vs.SYNC_PH) begin
            ph_d = 3'd0;
        end

        // An arm arriving on the apply edge survives for the next boundary.
        if (apply) begin
            mode_act_d = mode_pend_q;
            armed_d    = 1'b0;
        end
        if (hs_rise) begin
            armed_d = 1'b1;
        end

        if (vs.MODE_WR) begin
            mode_pend_d = vs.MODE_IN;
        end

        if (byte_end) begin
            border_d = ~vs.DISPEN;
        end
    end

    always_ff @(posedge CLK_n or negedge RESET_n) begin
        if (!RESET_n) begin
            ph_q        <= 3'd0;
            hsync_q     <= 1'b0;
            armed_q     <= 1'b0;
            mode_pend_q <= RESET_MODE;
            mode_act_q  <= RESET_MODE;
            border_q    <= 1'b1;
        end else begin
            ph_q        <= ph_d;
            hsync_q     <= hsync_d;
            armed_q     <= armed_d;
            mode_pend_q <= mode_pend_d;
            mode_act_q  <= mode_act_d;
            border_q    <= border_d;
        end
    end

    // LOAD owns the last phase of every mode, so SHIFT/KEEP only split phases 0..6.
    always_comb begin
        load_c  = byte_end;
        shift_c = 1'b0;
        if (!byte_end) begin
            unique case (mode_act_q)
                2'd2:    shift_c = 1'b1;
                2'd1:    shift_c = ph_q[0];
                default: shift_c = (ph_q == PH_MID);
            endcase
        end
        keep_c = ~load_c & ~shift_c;
    end

    assign vs.LOAD     = load_c;
    assign vs.SHIFT    = shift_c;
    assign vs.KEEP     = keep_c;
    assign vs.MODE_ACT = mode_act_q;
    assign vs.BORDER   = border_q;
    assign vs.PHASE    = ph_q;

    a_ctrl_onehot: assert property (@(posedge CLK_n) $onehot({load_c, shift_c, keep_c}));

    a_mode_boundary: assert property (@(posedge CLK_n) disable iff (!RESET_n)
        (mode_act_d != mode_act_q) |-> byte_end);

    a_border_boundary: assert property (@(posedge CLK_n) disable iff (!RESET_n)
        (border_d != border_q) |-> byte_end);

endmodule

// File: tb/tb_video_shift_ctrl.sv
module tb_video_shift_ctrl;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    video_shift_ctrl_if vif();

    video_shift_ctrl #(.RESET_MODE(2'd1)) dut (
        .CLK_n   (clk),
        .RESET_n (rst_n),
        .vs      (vif)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: byte position, pending/active mode, arm flag, border.
    int         m_ph;
    logic [1:0] m_pend;
    logic [1:0] m_act;
    bit         m_armed;
    bit         m_hs_prev;
    bit         m_border;
    logic [7:0] shift_mask [4];

    bit hs_lvl;
    bit den_lvl;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph      = 0;
        m_pend    = 2'd1;
        m_act     = 2'd1;
        m_armed   = 1'b0;
        m_hs_prev = 1'b0;
        m_border  = 1'b1;
    endtask

    task automatic model_edge(input bit sync, input bit hs, input bit wr,
                              input logic [1:0] din, input bit den);
        bit boundary;
        boundary = (m_ph == 7);
        if (boundary && m_armed) begin
            m_act   = m_pend;
            m_armed = 1'b0;
        end
        if (hs && !m_hs_prev) m_armed = 1'b1;
        if (wr) m_pend = din;
        if (boundary) m_border = !den;
        m_ph      = sync ? 0 : (m_ph + 1) % 8;
        m_hs_prev = hs;
    endtask

    task automatic check_outputs(input string tag);
        bit e_load, e_shift, e_keep;
        e_load  = (m_ph == 7);
        e_shift = !e_load && shift_mask[m_act][m_ph];
        e_keep  = !e_load && !e_shift;
        check_eq({tag, ".phase"},  8'(vif.PHASE),    8'(m_ph));
        check_eq({tag, ".load"},   8'(vif.LOAD),     8'(e_load));
        check_eq({tag, ".shift"},  8'(vif.SHIFT),    8'(e_shift));
        check_eq({tag, ".keep"},   8'(vif.KEEP),     8'(e_keep));
        check_eq({tag, ".mode"},   8'(vif.MODE_ACT), 8'(m_act));
        check_eq({tag, ".border"}, 8'(vif.BORDER),   8'(m_border));
        check_eq({tag, ".onehot"}, 8'(vif.KEEP) + 8'(vif.LOAD) + 8'(vif.SHIFT), 8'd1);
    endtask

    task automatic step(input bit sync, input bit wr, input logic [1:0] din, input string tag);
        vif.SYNC_PH = sync;
        vif.HSYNC   = hs_lvl;
        vif.MODE_WR = wr;
        vif.MODE_IN = din;
        vif.DISPEN  = den_lvl;
        @(posedge clk);
        model_edge(sync, hs_lvl, wr, din, den_lvl);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, tag);
    endtask

    task automatic goto_ph(input int p);
        for (int i = 0; i < 8 && m_ph != p; i++) step(1'b0, 1'b0, 2'd0, "goto");
    endtask

    // Drops reset between edges and checks the state clears without a clock.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs({tag, ".async"});
        @(posedge clk);
        @(negedge clk);
        check_outputs({tag, ".hold"});
        hs_lvl = 1'b0;
        rst_n  = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        shift_mask[0] = 8'b0000_1000;
        shift_mask[1] = 8'b0010_1010;
        shift_mask[2] = 8'b0111_1111;
        shift_mask[3] = 8'b0000_1000;
        vif.SYNC_PH = 1'b0;
        vif.HSYNC   = 1'b0;
        vif.MODE_WR = 1'b0;
        vif.MODE_IN = 2'd0;
        vif.DISPEN  = 1'b0;
        hs_lvl  = 1'b0;
        den_lvl = 1'b0;
        rst_n   = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        check_outputs("reset");
        check_eq("reset.keep_abs", 8'(vif.KEEP), 8'd1);
        rst_n = 1'b1;

        idle(16, "free");

        // Write mode 2 with no HSYNC: must stay in mode 1.
        goto_ph(2);
        step(1'b0, 1'b1, 2'd2, "wr2");
        idle(32, "nohs");
        check_eq("hold_mode1", 8'(vif.MODE_ACT), 8'd1);

        // HSYNC rise at PH3; write 0 on the apply edge: 2 applies, 0 stays pending.
        goto_ph(3);
        hs_lvl = 1'b1;
        step(1'b0, 1'b0, 2'd0, "hsrise");
        goto_ph(7);
        step(1'b0, 1'b1, 2'd0, "wr0_apply");
        check_eq("apply2", 8'(vif.MODE_ACT), 8'd2);
        idle(8, "mode2");
        hs_lvl = 1'b0;
        idle(2, "hslow");
        hs_lvl = 1'b1;
        idle(1, "hsrise2");
        goto_ph(7);
        step(1'b0, 1'b0, 2'd0, "apply0");
        check_eq("apply0", 8'(vif.MODE_ACT), 8'd0);
        idle(8, "mode0");
        hs_lvl = 1'b0;

        // Border for exactly one byte period.
        goto_ph(7);
        den_lvl = 1'b0;
        step(1'b0, 1'b0, 2'd0, "bord0");
        den_lvl = 1'b1;
        check_eq("border_set", 8'(vif.BORDER), 8'd1);
        idle(7, "bordhold");
        check_eq("border_held", 8'(vif.BORDER), 8'd1);
        step(1'b0, 1'b0, 2'd0, "bord1");
        check_eq("border_clr", 8'(vif.BORDER), 8'd0);

        // SYNC_PH at PH4 while armed: truncate, defer apply.
        goto_ph(0);
        step(1'b0, 1'b1, 2'd3, "wr3");
        hs_lvl = 1'b1;
        step(1'b0, 1'b0, 2'd0, "arm3");
        hs_lvl = 1'b0;
        goto_ph(4);
        step(1'b1, 1'b0, 2'd0, "syncph");
        check_eq("sync_phase0", 8'(vif.PHASE), 8'd0);
        check_eq("sync_defer", 8'(vif.MODE_ACT), 8'd0);
        goto_ph(7);
        step(1'b0, 1'b0, 2'd0, "apply3");
        check_eq("apply3", 8'(vif.MODE_ACT), 8'd3);

        // Mode 2 active, reset at PH5.
        step(1'b0, 1'b1, 2'd2, "wr2b");
        hs_lvl = 1'b1;
        step(1'b0, 1'b0, 2'd0, "arm2b");
        hs_lvl = 1'b0;
        idle(9, "run2b");
        check_eq("mode2_before_rst", 8'(vif.MODE_ACT), 8'd2);
        goto_ph(5);
        async_reset("rst_ph5");
        check_eq("rst_mode", 8'(vif.MODE_ACT), 8'd1);
        idle(16, "post_rst");

        for (int i = 0; i < 2400; i++) begin
            bit         s, w;
            logic [1:0] d;
            s = ($urandom_range(0, 15) == 0);
            w = ($urandom_range(0, 7) == 0);
            d = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) hs_lvl = ~hs_lvl;
            den_lvl = 1'($urandom_range(0, 1));
            step(s, w, d, "rand");
            if (i == 1200) async_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
